// File: rtl/nibble_ctrl.sv
// nibble_ctrl: fetch/decode/execute sequencer for the 4-bit nibble CPU.
// Owns pc, ir, accumulator and carry/zero flags; drives ROM, data-memory and I/O handshakes.
module nibble_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       halted,
    output logic       rom_en,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       mem_req,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [3:0] mem_wdata,
    input  logic [3:0] mem_rdata,
    input  logic       mem_ack,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] acc,
    output logic       carry,
    output logic       zero,
    output logic [7:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_IN,
        S_OUT,
        S_HALTED
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LIT   = 4'h1,
        OP_IN    = 4'h2,
        OP_LD    = 4'h3,
        OP_ST    = 4'h4,
        OP_ADD   = 4'h5,
        OP_MUL   = 4'h6,
        OP_NOR   = 4'h7,
        OP_OUT   = 4'h8,
        OP_JMP   = 4'h9,
        OP_JC    = 4'hA,
        OP_JZ    = 4'hB,
        OP_CLC   = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;

    opcode_e    op;
    logic [3:0] k;
    logic [7:0] pc_inc;
    logic [7:0] pc_jmp;
    logic [4:0] sum;
    logic [7:0] prod;
    logic       acc_wr;
    logic [3:0] acc_wr_val;

    assign op     = opcode_e'(ir_q[7:4]);
    assign k      = ir_q[3:0];
    assign pc_inc = pc_q + 8'd1;
    assign pc_jmp = {pc_q[7:4], k};
    assign sum    = {1'b0, acc_q} + {1'b0, mem_rdata};
    assign prod   = {4'b0000, acc_q} * {4'b0000, mem_rdata};

    // NOTE: async reset lives in the sensitivity list, and all state uses <= so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // NOTE: every variable gets a hold/default value first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        acc_wr     = 1'b0;
        acc_wr_val = acc_q;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (run) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: state_d = S_DECODE;

            S_DECODE: begin
                ir_d = rom_data;
                case (opcode_e'(rom_data[7:4]))
                    OP_LD, OP_ST, OP_ADD, OP_MUL, OP_NOR: state_d = S_MEM;
                    OP_IN:   state_d = S_IN;
                    OP_OUT:  state_d = S_OUT;
                    OP_HALT: state_d = S_HALTED;
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_LIT: begin
                        acc_wr     = 1'b1;
                        acc_wr_val = k;
                    end
                    OP_JMP: pc_d = pc_jmp;
                    OP_JC:  if (carry_q) pc_d = pc_jmp;
                    OP_JZ:  if (zero_q) pc_d = pc_jmp;
                    OP_CLC: carry_d = 1'b0;
                    default: ;
                endcase
            end

            S_MEM: begin
                if (mem_ack) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    case (op)
                        OP_LD: begin
                            acc_wr     = 1'b1;
                            acc_wr_val = mem_rdata;
                        end
                        OP_ADD: begin
                            acc_wr     = 1'b1;
                            acc_wr_val = sum[3:0];
                            carry_d    = sum[4];
                        end
                        OP_MUL: begin
                            acc_wr     = 1'b1;
                            acc_wr_val = prod[3:0];
                            carry_d    = |prod[7:4];
                        end
                        OP_NOR: begin
                            acc_wr     = 1'b1;
                            acc_wr_val = ~(acc_q | mem_rdata);
                        end
                        default: ;
                    endcase
                end
            end

            S_IN: begin
                if (in_valid) begin
                    state_d    = S_FETCH;
                    pc_d       = pc_inc;
                    acc_wr     = 1'b1;
                    acc_wr_val = in_data;
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Zero tracks every accumulator write, whatever instruction caused it.
        if (acc_wr) begin
            acc_d  = acc_wr_val;
            zero_d = (acc_wr_val == 4'h0);
        end
    end

    // Strobes and port data decode straight from state, so reset clears them at once.
    assign halted    = (state_q == S_HALTED);
    assign rom_en    = (state_q == S_FETCH);
    assign rom_addr  = pc_q;
    assign mem_req   = (state_q == S_MEM);
    assign mem_we    = mem_req && (op == OP_ST);
    assign mem_addr  = mem_req ? k : 4'h0;
    assign mem_wdata = mem_req ? acc_q : 4'h0;
    assign in_ready  = (state_q == S_IN);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_valid ? acc_q : 4'h0;
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_nibble_ctrl.sv
// Bench for nibble_ctrl: bench-owned ROM image, data memory and I/O responders,
// with an instruction-level reference model of acc/flags/pc/memory.
module tb_nibble_ctrl;

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic       run;
    logic       halted;
    logic       rom_en;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       mem_req;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;
    logic       mem_ack;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc;
    logic       carry;
    logic       zero;
    logic [7:0] pc;

    nibble_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .halted    (halted),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero),
        .pc        (pc)
    );

    logic [7:0] rom_img [256];
    assign rom_data = rom_img[rom_addr];

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural reference state
    int m_pc, m_acc, m_c, m_z;
    int m_mem [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_regs(input string tag, input int a, input int c, input int z);
        check({tag, "_acc"}, acc, a);
        check({tag, "_carry"}, carry, c);
        check({tag, "_zero"}, zero, z);
    endtask

    task automatic set_acc(input int v);
        m_acc = v % 16;
        m_z   = (m_acc == 0) ? 1 : 0;
    endtask

    function automatic logic [7:0] rand_filler();
        int r;
        logic [3:0] o;
        logic [3:0] kk;
        r  = $urandom_range(0, 11);
        o  = (r <= 8) ? 4'(r) : 4'(r + 3);
        kk = 4'($urandom_range(0, 15));
        return {o, kk};
    endfunction

    // Entered in FETCH (#1 after the edge); returns in the next FETCH, or in HALTED.
    task automatic exec_one(input int waits, input int din);
        logic [7:0] ins;
        logic [3:0] op;
        logic [3:0] kk;
        int s;
        ins = rom_img[m_pc];
        op  = ins[7:4];
        kk  = ins[3:0];
        check("fetch_rom_en", rom_en, 1);
        check("fetch_rom_addr", rom_addr, m_pc);
        chk_regs("arch", m_acc, m_c, m_z);
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("decode_strobes", {rom_en, mem_req, in_ready, out_valid, halted}, 0);
        mem_ack = 1'($urandom_range(0, 1));
        run     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        mem_ack = 1'b0;
        run     = 1'b0;

        if (op >= 4'h3 && op <= 4'h7) begin
            for (int w = 0; w <= waits; w++) begin
                check("mem_req", mem_req, 1);
                check("mem_addr", mem_addr, kk);
                check("mem_we", mem_we, (op == 4'h4) ? 1 : 0);
                check("mem_wdata", mem_wdata, m_acc);
                mem_ack   = (w == waits);
                mem_rdata = (w == waits) ? 4'(m_mem[kk]) : 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
        end else if (op == 4'h2) begin
            for (int w = 0; w <= waits; w++) begin
                check("in_ready", in_ready, 1);
                in_valid = (w == waits);
                in_data  = (w == waits) ? 4'(din) : 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end else if (op == 4'h8) begin
            for (int w = 0; w <= waits; w++) begin
                check("out_valid", out_valid, 1);
                check("out_data", out_data, m_acc);
                out_ready = (w == waits);
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
        end else if (op == 4'hF) begin
            check("halt_flag", halted, 1);
            check("halt_pc", pc, m_pc);
            check("halt_rom_en", rom_en, 0);
            return;
        end else begin
            check("exec_strobes", {rom_en, mem_req, in_ready, out_valid, halted}, 0);
            @(posedge clk); #1;
        end

        s = -1;
        case (op)
            4'h1: set_acc(kk);
            4'h2: set_acc(din);
            4'h3: set_acc(m_mem[kk]);
            4'h4: m_mem[kk] = m_acc;
            4'h5: begin s = m_acc + m_mem[kk]; m_c = (s > 15) ? 1 : 0; set_acc(s); end
            4'h6: begin s = m_acc * m_mem[kk]; m_c = (s >= 16) ? 1 : 0; set_acc(s); end
            4'h7: set_acc(15 - (m_acc | m_mem[kk]));
            4'hC: m_c = 0;
            default: ;
        endcase
        if (op == 4'h9 || (op == 4'hA && m_c == 1) || (op == 4'hB && m_z == 1))
            m_pc = (m_pc & 240) | kk;
        else
            m_pc = (m_pc + 1) % 256;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(posedge clk); #1;
        run  = 1'b0;
        m_pc = 0;
    endtask

    task automatic rand_exec();
        exec_one($urandom_range(0, 3), $urandom_range(0, 15));
    endtask

    initial begin
        run = 0; mem_ack = 0; mem_rdata = 0; in_data = 0; in_valid = 0; out_ready = 0;
        clk_en = 0; reset = 0;
        m_pc = 0; m_acc = 0; m_c = 0; m_z = 1;
        for (int i = 0; i < 16; i++) m_mem[i] = $urandom_range(0, 15);
        m_mem[2] = 2; m_mem[3] = 8; m_mem[4] = 4; m_mem[5] = 5;

        for (int i = 0; i < 256; i++) rom_img[i] = 8'h00;
        rom_img[8'h00] = 8'h19; rom_img[8'h01] = 8'h53; rom_img[8'h02] = 8'hC0;
        rom_img[8'h03] = 8'h17; rom_img[8'h04] = 8'h62; rom_img[8'h05] = 8'h15;
        rom_img[8'h06] = 8'h64; rom_img[8'h07] = 8'h1A; rom_img[8'h08] = 8'h75;
        rom_img[8'h09] = 8'h1B; rom_img[8'h0A] = 8'h47; rom_img[8'h0B] = 8'h20;
        rom_img[8'h0C] = 8'h80;
        for (int i = 8'h0D; i < 8'h20; i++) rom_img[i] = rand_filler();
        rom_img[8'h20] = 8'h11; rom_img[8'h21] = 8'h41; rom_img[8'h22] = 8'h1F;
        rom_img[8'h23] = 8'h51; rom_img[8'h24] = 8'h41; rom_img[8'h25] = 8'hA3;
        rom_img[8'h26] = 8'hB8; rom_img[8'h27] = 8'hF0; rom_img[8'h28] = 8'h9F;
        for (int i = 8'h2F; i < 8'hFF; i++) rom_img[i] = rand_filler();
        rom_img[8'hFF] = 8'h00;

        // Reset with the clock stopped
        #1 reset = 1'b1;
        #2;
        check("rst_strobes", {rom_en, mem_req, mem_we, in_ready, out_valid, halted}, 0);
        check("rst_ports", {mem_addr, mem_wdata, out_data}, 0);
        check("rst_pc", pc, 0);
        chk_regs("rst", 0, 0, 1);
        #3 reset = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_wait", {rom_en, halted}, 0);

        pulse_run();
        exec_one(0, 0);                   chk_regs("lit9", 9, 0, 0);
        exec_one($urandom_range(0, 3), 0); chk_regs("add_carry", 1, 1, 0);
        exec_one(0, 0);                   chk_regs("clc", 1, 0, 0);
        exec_one(0, 0);
        exec_one($urandom_range(0, 3), 0); chk_regs("mul_7x2", 14, 0, 0);
        exec_one(0, 0);
        exec_one(0, 0);                   chk_regs("mul_5x4", 4, 1, 0);
        exec_one(0, 0);
        exec_one(1, 0);                   chk_regs("nor", 0, 1, 1);
        exec_one(0, 0);
        exec_one(2, 0);                   check("st_wait_pc", pc, 8'h0B);
        exec_one(4, 6);                   chk_regs("in_wait", 6, 1, 0);
        exec_one(2, 0);                   check("out_wait_pc", pc, 8'h0D);

        for (int i = 0; i < 64 && m_pc != 8'h20; i++) rand_exec();
        check("reach_20", pc, 8'h20);
        repeat (6) rand_exec();
        check("jc_taken", pc, 8'h23);
        repeat (3) rand_exec();
        check("jc_not_taken", pc, 8'h26);
        rand_exec();
        check("jz_taken", pc, 8'h28);
        rand_exec();
        check("jmp", pc, 8'h2F);

        for (int i = 0; i < 300 && m_pc != 8'hFF; i++) rand_exec();
        check("reach_ff", pc, 8'hFF);
        rand_exec();
        check("wrap_rom_addr", rom_addr, 8'h00);
        rand_exec();

        // Abandon an ADD mid-MEM with reset, no clock edge in between
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_mem_req", mem_req, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_strobes", {rom_en, mem_req, mem_we, in_ready, out_valid, halted}, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_pc", pc, 0);
        chk_regs("mid_rst", 0, 0, 1);
        #2 reset = 1'b0;
        m_pc = 0; m_acc = 0; m_c = 0; m_z = 1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {rom_en, mem_req, halted}, 0);

        // Second program: random body ending in HALT at 0x0A
        for (int i = 0; i < 256; i++) rom_img[i] = 8'h00;
        for (int i = 0; i < 8'h0A; i++) rom_img[i] = rand_filler();
        rom_img[8'h0A] = 8'hF0;
        for (int pass = 0; pass < 2; pass++) begin
            pulse_run();
            for (int i = 0; i < 20 && rom_img[m_pc][7:4] != 4'hF; i++) rand_exec();
            rand_exec();
            check("halt_at_0a", pc, 8'h0A);
            repeat (3) @(posedge clk);
            #1;
            check("halt_hold", {halted, rom_en}, 2'b10);
            check("halt_hold_pc", pc, 8'h0A);
            chk_regs("halt_hold", m_acc, m_c, m_z);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
